serv_rf_ram_if_seq: RTL and testbench

Sequential bridge between the core's W-bit serial register-file ports and a 1R1W synchronous RAM of `width`-bit words. It sits directly downstream of the register-file interface. The write side packs two serial write streams into RAM words. The read side time-multiplexes one RAM read port into two continuous serial read streams, with prefetching. GPRs and CSR slots share one RAM; x0 always reads as zero.

---
 rtl/serv_rf_ram_if_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_serv_rf_ram_if_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_rf_ram_if_seq.sv
// serv_rf_ram_if_seq
// Sequential bridge between the core's W-bit serial register-file ports and a
// 1R1W synchronous RAM of `width`-bit words.
//  - Write side: two serial write streams are packed into RAM words. Each
//    completed word waits in a per-port pending register; port 0 drains first.
//  - Read side: one RAM read port is time-multiplexed into two continuous
//    serial read streams. Word 0 of both operands is fetched up front, and
//    each later word is prefetched while the previous word is being shifted out.
//  - Register x0 always reads as zero.
// Ports:
//  clk, i_rst                  clock, synchronous active-high reset
//  i_wreg0/1, i_wen0/1,
//  i_wdata0/1                  serial write ports (address, chunk strobe, chunk)
//  i_rreq, i_rreg0/1           read request pulse and the two read addresses
//  o_ready                     pulse one cycle before streaming begins
//  o_rdata0/1                  serial read chunks, LSB first
//  o_waddr, o_wdata, o_wen     RAM write port
//  o_raddr, o_ren, i_rdata     RAM read port (data valid the cycle after o_ren)
module serv_rf_ram_if_seq #(
    parameter int W        = 1,
    parameter int width    = 8,
    parameter int WITH_CSR = 1,
    localparam int RW = 5 + WITH_CSR,
    localparam int N  = 32 / width,
    localparam int LN = $clog2(N),
    localparam int AW = RW + LN
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic [RW-1:0]    i_wreg0,
    input  logic [RW-1:0]    i_wreg1,
    input  logic             i_wen0,
    input  logic             i_wen1,
    input  logic [W-1:0]     i_wdata0,
    input  logic [W-1:0]     i_wdata1,
    input  logic             i_rreq,
    input  logic [RW-1:0]    i_rreg0,
    input  logic [RW-1:0]    i_rreg1,
    output logic             o_ready,
    output logic [W-1:0]     o_rdata0,
    output logic [W-1:0]     o_rdata1,
    output logic [AW-1:0]    o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [AW-1:0]    o_raddr,
    output logic             o_ren,
    input  logic [width-1:0] i_rdata
);

    localparam int R  = width / W;      // cycles per RAM word
    localparam int LR = $clog2(R);
    localparam int CW = $clog2(32 / W); // chunk counter width

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic [CW-1:0]      wcnt;
    logic [width-W-1:0] wbuf0, wbuf1;   // chunks collected so far in this word
    logic [width-1:0]   wword0, wword1; // word as it looks with this cycle's chunk
    logic               wlast;
    logic [LN-1:0]      widx;
    logic               pend0, pend1;
    logic [width-1:0]   pdata0, pdata1;
    logic [AW-1:0]      paddr0, paddr1;

    assign wword0 = {i_wdata0, wbuf0};
    assign wword1 = {i_wdata1, wbuf1};
    assign wlast  = &wcnt[LR-1:0];
    assign widx   = wcnt[CW-1:LR];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            wcnt  <= '0;
            pend0 <= 1'b0;
            pend1 <= 1'b0;
        end else begin
            if (i_wen0 | i_wen1)
                wcnt <= wcnt + 1'b1;
            // Port 0 always drains the cycle after it fills, so its flag is
            // simply "a word completed last cycle".
            pend0 <= i_wen0 & wlast;
            // Port 1 waits one extra cycle whenever port 0 holds the RAM.
            if (i_wen1 && wlast)
                pend1 <= 1'b1;
            else if (!pend0)
                pend1 <= 1'b0;
        end
    end

    // NOTE: pure datapath registers carry no reset; the valid flags above
    // decide when their contents are used, so reset only costs area here.
    always_ff @(posedge clk) begin
        if (i_wen0)
            wbuf0 <= wword0[width-1:W];
        if (i_wen1)
            wbuf1 <= wword1[width-1:W];
        if (i_wen0 && wlast) begin
            pdata0 <= wword0;
            paddr0 <= {i_wreg0, widx};
        end
        if (i_wen1 && wlast) begin
            pdata1 <= wword1;
            paddr1 <= {i_wreg1, widx};
        end
    end

    assign o_wen   = pend0 | pend1;
    assign o_waddr = pend0 ? paddr0 : paddr1;
    assign o_wdata = pend0 ? pdata0 : pdata1;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, PRE, STREAM} rd_state_t;

    rd_state_t        state, state_next;
    logic [1:0]       pre_cnt;
    logic [LR-1:0]    p;
    logic [LN-1:0]    k;
    logic [LN-1:0]    k_inc;
    logic             k_last;
    logic [RW-1:0]    rs1_q, rs2_q;
    logic             rd_port1;         // current RAM read belongs to rs2
    logic             cap0_q, cap1_q;   // i_rdata this cycle belongs to rs1 / rs2
    logic [width-1:0] rd_word0, rd_word1;
    logic [width-1:0] hold0, hold1;
    logic [width-1:0] hold0_eff, hold1_eff;
    logic [width-1:0] shift0, shift1;

    assign k_inc  = k + 1'b1;
    assign k_last = (k == LN'(N - 1));

    // x0 is never written to a meaningful value in RAM, so mask it here.
    assign rd_word0 = (rs1_q == '0) ? '0 : i_rdata;
    assign rd_word1 = (rs2_q == '0) ? '0 : i_rdata;

    // The rs2 word fetched last in PRE arrives in the same cycle it must be
    // transferred, so the transfer path bypasses the hold register.
    assign hold0_eff = cap0_q ? rd_word0 : hold0;
    assign hold1_eff = cap1_q ? rd_word1 : hold1;

    always_ff @(posedge clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        o_ren      = 1'b0;
        o_raddr    = '0;
        o_ready    = 1'b0;
        rd_port1   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_rreq)
                    state_next = PRE;
            end
            PRE: begin
                case (pre_cnt)
                    2'd0: begin
                        o_ren   = 1'b1;
                        o_raddr = {rs1_q, {LN{1'b0}}};
                    end
                    2'd1: begin
                        o_ren    = 1'b1;
                        o_raddr  = {rs2_q, {LN{1'b0}}};
                        rd_port1 = 1'b1;
                    end
                    default: begin
                        o_ready    = 1'b1;
                        state_next = STREAM;
                    end
                endcase
            end
            STREAM: begin
                if (!k_last && p == LR'(0)) begin
                    o_ren   = 1'b1;
                    o_raddr = {rs1_q, k_inc};
                end
                if (!k_last && p == LR'(1)) begin
                    o_ren    = 1'b1;
                    o_raddr  = {rs2_q, k_inc};
                    rd_port1 = 1'b1;
                end
                if (k_last && &p)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            pre_cnt <= '0;
            p       <= '0;
            k       <= '0;
            cap0_q  <= 1'b0;
            cap1_q  <= 1'b0;
            shift0  <= '0;
            shift1  <= '0;
        end else begin
            cap0_q <= o_ren & ~rd_port1;
            cap1_q <= o_ren & rd_port1;
            unique case (state)
                PRE: begin
                    pre_cnt <= pre_cnt + 1'b1;
                    if (pre_cnt == 2'd2) begin
                        shift0 <= hold0_eff;
                        shift1 <= hold1_eff;
                    end
                end
                STREAM: begin
                    p <= p + 1'b1;
                    if (&p) begin
                        k <= k_inc;
                        // After the last word, shift in zeros rather than
                        // replaying a stale hold register.
                        shift0 <= k_last ? '0 : hold0_eff;
                        shift1 <= k_last ? '0 : hold1_eff;
                    end else begin
                        shift0 <= shift0 >> W;
                        shift1 <= shift1 >> W;
                    end
                end
                default: begin
                    pre_cnt <= '0;
                    p       <= '0;
                    k       <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && i_rreq) begin
            rs1_q <= i_rreg0;
            rs2_q <= i_rreg1;
        end
        if (cap0_q)
            hold0 <= rd_word0;
        if (cap1_q)
            hold1 <= rd_word1;
    end

    assign o_rdata0 = shift0[W-1:0];
    assign o_rdata1 = shift1[W-1:0];

endmodule

// File: tb/tb_serv_rf_ram_if_seq.sv
// Testbench for serv_rf_ram_if_seq (W=1, width=8, WITH_CSR=1).
// A behavioural RAM sits on the DUT's RAM ports. A register-file model holds
// the 32-bit value of every register; read and write tasks turn that model
// into per-cycle expectations using the documented cycle offsets, and a single
// negedge process compares every cycle. A few literal values pin the model.
module tb_serv_rf_ram_if_seq;

    localparam int W        = 1;
    localparam int WIDTH    = 8;
    localparam int WITH_CSR = 1;
    localparam int RW       = 6;
    localparam int N        = 4;
    localparam int AW       = 8;
    localparam int R        = 8;

    logic             clk;
    logic             i_rst;
    logic [RW-1:0]    i_wreg0, i_wreg1;
    logic             i_wen0, i_wen1;
    logic [W-1:0]     i_wdata0, i_wdata1;
    logic             i_rreq;
    logic [RW-1:0]    i_rreg0, i_rreg1;
    logic             o_ready;
    logic [W-1:0]     o_rdata0, o_rdata1;
    logic [AW-1:0]    o_waddr;
    logic [WIDTH-1:0] o_wdata;
    logic             o_wen;
    logic [AW-1:0]    o_raddr;
    logic             o_ren;
    logic [WIDTH-1:0] i_rdata;

    serv_rf_ram_if_seq #(.W(W), .width(WIDTH), .WITH_CSR(WITH_CSR)) dut (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_wreg0  (i_wreg0),
        .i_wreg1  (i_wreg1),
        .i_wen0   (i_wen0),
        .i_wen1   (i_wen1),
        .i_wdata0 (i_wdata0),
        .i_wdata1 (i_wdata1),
        .i_rreq   (i_rreq),
        .i_rreg0  (i_rreg0),
        .i_rreg1  (i_rreg1),
        .o_ready  (o_ready),
        .o_rdata0 (o_rdata0),
        .o_rdata1 (o_rdata1),
        .o_waddr  (o_waddr),
        .o_wdata  (o_wdata),
        .o_wen    (o_wen),
        .o_raddr  (o_raddr),
        .o_ren    (o_ren),
        .i_rdata  (i_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM plus a preload port driven by the stimulus process.
    logic [WIDTH-1:0] ram [256];
    logic [WIDTH-1:0] rdata_q;
    logic             pl_we;
    logic [AW-1:0]    pl_addr;
    logic [WIDTH-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_we) ram[pl_addr] <= pl_data;
        if (o_wen) ram[o_waddr] <= o_wdata;
        if (o_ren) rdata_q <= ram[o_raddr];
    end
    assign i_rdata = rdata_q;

    // Reference register file and per-cycle expectations.
    logic [31:0]      model_reg [36];
    logic [AW-1:0]    exp_raddr [int];
    bit               exp_ready [int];
    logic [AW-1:0]    exp_waddr [int];
    logic [WIDTH-1:0] exp_wdata [int];
    logic             exp_rd0   [int];
    logic             exp_rd1   [int];
    logic [AW-1:0]    lit_raddr [int];
    logic [AW-1:0]    lit_waddr [int];
    logic [WIDTH-1:0] lit_wdata [int];
    logic             lit_rd0   [int];
    logic             lit_rd1   [int];
    bit               rst_chk   [int];
    bit               strict;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (strict) begin
            check("ren", 32'(o_ren), 32'(exp_raddr.exists(cyc)));
            if (exp_raddr.exists(cyc)) check("raddr", 32'(o_raddr), 32'(exp_raddr[cyc]));
            check("ready", 32'(o_ready), 32'(exp_ready.exists(cyc)));
            check("wen", 32'(o_wen), 32'(exp_waddr.exists(cyc)));
            if (exp_waddr.exists(cyc)) begin
                check("waddr", 32'(o_waddr), 32'(exp_waddr[cyc]));
                check("wdata", 32'(o_wdata), 32'(exp_wdata[cyc]));
            end
        end
        if (exp_rd0.exists(cyc)) check("rdata0", 32'(o_rdata0), 32'(exp_rd0[cyc]));
        if (exp_rd1.exists(cyc)) check("rdata1", 32'(o_rdata1), 32'(exp_rd1[cyc]));
        if (lit_raddr.exists(cyc)) begin
            check("lit_ren", 32'(o_ren), 32'd1);
            check("lit_raddr", 32'(o_raddr), 32'(lit_raddr[cyc]));
        end
        if (lit_waddr.exists(cyc)) begin
            check("lit_wen", 32'(o_wen), 32'd1);
            check("lit_waddr", 32'(o_waddr), 32'(lit_waddr[cyc]));
        end
        if (lit_wdata.exists(cyc)) check("lit_wdata", 32'(o_wdata), 32'(lit_wdata[cyc]));
        if (lit_rd0.exists(cyc)) check("lit_rdata0", 32'(o_rdata0), 32'(lit_rd0[cyc]));
        if (lit_rd1.exists(cyc)) check("lit_rdata1", 32'(o_rdata1), 32'(lit_rd1[cyc]));
        if (rst_chk.exists(cyc)) begin
            check("rst_wen", 32'(o_wen), 32'd0);
            check("rst_ren", 32'(o_ren), 32'd0);
            check("rst_ready", 32'(o_ready), 32'd0);
            check("rst_rdata0", 32'(o_rdata0), 32'd0);
            check("rst_rdata1", 32'(o_rdata1), 32'd0);
        end
    end

    function automatic logic [AW-1:0] ram_addr(input int r, input int k);
        return AW'(r * N + k);
    endfunction

    function automatic logic [31:0] val(input int r);
        return (r == 0) ? 32'h0 : model_reg[r];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload_word(input int addr, input logic [WIDTH-1:0] data);
        pl_we   = 1'b1;
        pl_addr = AW'(addr);
        pl_data = data;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic preload_reg(input int r, input logic [31:0] v);
        for (int k = 0; k < N; k++) preload_word(r * N + k, v[k*WIDTH +: WIDTH]);
        model_reg[r] = v;
    endtask

    // Read request at the current cycle c0; optional ignored re-request at c0+ign_at.
    task automatic do_read(input int rs1, input int rs2, input int ign_at, input int ign_r);
        int c0;
        logic [31:0] v1, v2;
        c0 = cyc;
        v1 = val(rs1);
        v2 = val(rs2);
        exp_raddr[c0+1] = ram_addr(rs1, 0);
        exp_raddr[c0+2] = ram_addr(rs2, 0);
        exp_ready[c0+3] = 1'b1;
        for (int k = 1; k < N; k++) begin
            exp_raddr[c0+4+(k-1)*R] = ram_addr(rs1, k);
            exp_raddr[c0+5+(k-1)*R] = ram_addr(rs2, k);
        end
        for (int i = 0; i < 32; i++) begin
            exp_rd0[c0+4+i] = v1[i];
            exp_rd1[c0+4+i] = v2[i];
        end
        i_rreq  = 1'b1;
        i_rreg0 = RW'(rs1);
        i_rreg1 = RW'(rs2);
        tick();
        i_rreq = 1'b0;
        for (int t = 1; t < 36; t++) begin
            if (t == ign_at) begin
                i_rreq  = 1'b1;
                i_rreg0 = RW'(ign_r);
                i_rreg1 = RW'(ign_r);
            end
            tick();
            i_rreq = 1'b0;
        end
    endtask

    // 32 chunks per enabled port; gap_len idle cycles inserted before chunk gap_at.
    task automatic do_write(input bit en0, input int r0, input logic [31:0] v0,
                            input bit en1, input int r1, input logic [31:0] v1,
                            input int gap_at, input int gap_len);
        i_wreg0 = RW'(r0);
        i_wreg1 = RW'(r1);
        for (int i = 0; i < 32; i++) begin
            if (i == gap_at) begin
                i_wen0 = 1'b0;
                i_wen1 = 1'b0;
                repeat (gap_len) tick();
            end
            i_wen0   = en0;
            i_wen1   = en1;
            i_wdata0 = v0[i];
            i_wdata1 = v1[i];
            if (i % R == R - 1) begin
                if (en0) begin
                    exp_waddr[cyc+1] = ram_addr(r0, i / R);
                    exp_wdata[cyc+1] = v0[(i/R)*WIDTH +: WIDTH];
                end
                if (en1) begin
                    exp_waddr[cyc+1+int'(en0)] = ram_addr(r1, i / R);
                    exp_wdata[cyc+1+int'(en0)] = v1[(i/R)*WIDTH +: WIDTH];
                end
            end
            tick();
        end
        i_wen0 = 1'b0;
        i_wen1 = 1'b0;
        if (en0) model_reg[r0] = v0;
        if (en1) model_reg[r1] = v1;
        tick();
        tick();
    endtask

    initial begin
        int c0;
        logic [7:0] pat0, pat1;
        i_rst    = 1'b1;
        i_wreg0  = '0;
        i_wreg1  = '0;
        i_wen0   = 1'b0;
        i_wen1   = 1'b0;
        i_wdata0 = '0;
        i_wdata1 = '0;
        i_rreq   = 1'b0;
        i_rreg0  = '0;
        i_rreg1  = '0;
        pl_we    = 1'b0;
        pl_addr  = '0;
        pl_data  = '0;
        strict   = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
        rst_chk[cyc] = 1'b1;
        strict = 1'b1;

        preload_reg(5, 32'hA5A5F00F);
        preload_reg(7, 32'h12345678);
        preload_reg(3, 32'h0F1E2D3C);
        preload_word(0, 8'hFF);

        // Basic read, with literal addresses and bits pinned.
        c0 = cyc;
        lit_raddr[c0+1]  = 8'd20;
        lit_raddr[c0+2]  = 8'd28;
        lit_raddr[c0+4]  = 8'd21;
        lit_raddr[c0+13] = 8'd30;
        lit_rd0[c0+4]    = 1'b1;
        lit_rd0[c0+8]    = 1'b0;
        lit_rd0[c0+16]   = 1'b1;
        lit_rd0[c0+35]   = 1'b1;
        lit_rd1[c0+4]    = 1'b0;
        lit_rd1[c0+7]    = 1'b1;
        do_read(5, 7, -1, 0);

        // x0 reads as zero even though RAM word 0 holds 0xFF.
        do_read(0, 3, -1, 0);

        // Second request mid-stream must be ignored.
        do_read(7, 5, 10, 3);

        // Dual write: port 1 trails port 0 by one cycle.
        c0 = cyc;
        lit_waddr[c0+8]  = 8'd36;  lit_wdata[c0+8]  = 8'hEF;
        lit_waddr[c0+9]  = 8'd132; lit_wdata[c0+9]  = 8'h0D;
        lit_waddr[c0+32] = 8'd39;  lit_wdata[c0+32] = 8'h89;
        lit_waddr[c0+33] = 8'd135; lit_wdata[c0+33] = 8'h0B;
        do_write(1'b1, 9, 32'h89ABCDEF, 1'b1, 33, 32'h0BADF00D, -1, 0);
        do_read(9, 33, -1, 0);

        // Port 0 only, with a 3-cycle gap in the first word.
        c0 = cyc;
        lit_waddr[c0+11] = 8'd40; lit_wdata[c0+11] = 8'hBE;
        lit_waddr[c0+19] = 8'd41; lit_wdata[c0+19] = 8'hBA;
        do_write(1'b1, 10, 32'hCAFEBABE, 1'b0, 0, 32'h0, 4, 3);
        do_read(10, 9, -1, 0);

        // Reset during STREAM while both ports have a word pending.
        strict  = 1'b0;
        pat0    = 8'h5A;
        pat1    = 8'hC3;
        c0      = cyc;
        i_rreq  = 1'b1;
        i_rreg0 = RW'(5);
        i_rreg1 = RW'(7);
        i_wreg0 = RW'(20);
        i_wreg1 = RW'(21);
        for (int i = 0; i < 8; i++) begin
            i_wen0   = 1'b1;
            i_wen1   = 1'b1;
            i_wdata0 = pat0[i];
            i_wdata1 = pat1[i];
            tick();
            i_rreq = 1'b0;
        end
        lit_waddr[c0+8] = 8'd80;
        lit_wdata[c0+8] = 8'h5A;
        i_wen0 = 1'b0;
        i_wen1 = 1'b0;
        i_rst  = 1'b1;
        tick();
        i_rst = 1'b0;
        rst_chk[cyc]   = 1'b1;
        rst_chk[cyc+1] = 1'b1;
        tick();
        strict = 1'b1;
        do_read(7, 5, -1, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
